// File: rtl/jk_seq_checker.sv
// jk_seq_checker: watches a 3-bit Johnson-like counter {a,b,c} and checks each
// valid sample against a fixed 8-state successor table. Once LOCK_N consecutive
// correct transitions are seen it declares lock. While locked it counts
// mismatches, and drops lock after LOSS_N consecutive mismatches.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   rst      - synchronous active-high reset
//   in_valid - {a,b,c} carries a sample this cycle
//   a, b, c  - observed counter bits, a is the MSB
//   locked   - high while in LOCKED
//   err      - one-cycle pulse per mismatch detected while locked
//   err_cnt  - mismatches seen while locked since reset, saturating at 255
//   expected - predicted next {a,b,c}, meaningful only while locked
module jk_seq_checker #(
  parameter int unsigned LOCK_N = 2,
  parameter int unsigned LOSS_N = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [2:0] expected
);

  localparam logic [3:0] LockN = 4'(LOCK_N);
  localparam logic [3:0] LossN = 4'(LOSS_N);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic       prev_ok_q, prev_ok_d;
  logic [2:0] match_cnt_q, match_cnt_d;
  logic [2:0] miss_cnt_q, miss_cnt_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic [2:0] sample;
  logic [2:0] nxt;
  logic       hit;

  function automatic logic [2:0] succ(input logic [2:0] s);
    logic [2:0] r;
    case (s)
      3'b000:  r = 3'b101;
      3'b101:  r = 3'b010;
      3'b010:  r = 3'b001;
      3'b001:  r = 3'b111;
      3'b111:  r = 3'b110;
      3'b110:  r = 3'b011;
      3'b011:  r = 3'b100;
      3'b100:  r = 3'b000;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  assign sample = {a, b, c};
  assign nxt    = succ(prev_q);
  assign hit    = (sample == nxt);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      // Every accepted sample becomes the new reference, so a mismatch
      // resynchronises on what was actually observed.
      prev_d = sample;
      case (state_q)
        StHunt: begin
          if (!prev_ok_q) begin
            prev_ok_d = 1'b1;
          end else if (hit) begin
            if ({1'b0, match_cnt_q} + 4'd1 == LockN) begin
              state_d     = StLocked;
              match_cnt_d = 3'd0;
              miss_cnt_d  = 3'd0;
            end else begin
              match_cnt_d = match_cnt_q + 3'd1;
            end
          end else begin
            match_cnt_d = 3'd0;
          end
        end
        StLocked: begin
          if (hit) begin
            miss_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
            if ({1'b0, miss_cnt_q} + 4'd1 == LossN) begin
              state_d     = StHunt;
              match_cnt_d = 3'd0;
              miss_cnt_d  = 3'd0;
            end else begin
              miss_cnt_d = miss_cnt_q + 3'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      prev_q      <= 3'b000;
      prev_ok_q   <= 1'b0;
      match_cnt_q <= 3'd0;
      miss_cnt_q  <= 3'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked   = (state_q == StLocked);
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign expected = nxt;

endmodule

// File: tb/tb_jk_seq_checker.sv
// Bench for jk_seq_checker: two instances (default LOSS_N=3 and LOSS_N=7) share
// one input stream; a behavioural model of each is stepped alongside.
module tb_jk_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0;
  logic       lock_a, err_a, lock_b, err_b;
  logic [7:0] cnt_a, cnt_b;
  logic [2:0] exp_a, exp_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_seq_checker u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .locked(lock_a), .err(err_a), .err_cnt(cnt_a), .expected(exp_a)
  );

  jk_seq_checker #(.LOCK_N(2), .LOSS_N(7)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .locked(lock_b), .err(err_b), .err_cnt(cnt_b), .expected(exp_b)
  );

  // Counter cycle written as an ordered ring; successor is the following entry.
  logic [2:0] ring [8];
  initial begin
    ring[0] = 3'd0; ring[1] = 3'd5; ring[2] = 3'd2; ring[3] = 3'd1;
    ring[4] = 3'd7; ring[5] = 3'd6; ring[6] = 3'd3; ring[7] = 3'd4;
  end

  function automatic logic [2:0] succ(input logic [2:0] s);
    for (int i = 0; i < 8; i++) if (ring[i] == s) return ring[(i + 1) % 8];
    return 3'd0;
  endfunction

  // Model state per instance (0 = LOSS_N 3, 1 = LOSS_N 7).
  int   loss_n [2] = '{3, 7};
  bit   m_lock [2];
  bit   m_err  [2];
  bit   m_pok  [2];
  int   m_prev [2];
  int   m_hits [2];
  int   m_miss [2];
  int   m_cnt  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [2:0] s);
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      if (r) begin
        m_lock[k] = 0; m_pok[k] = 0; m_prev[k] = 0;
        m_hits[k] = 0; m_miss[k] = 0; m_cnt[k] = 0;
      end else if (v) begin
        bit good;
        good = (s == succ(3'(m_prev[k])));
        if (!m_lock[k]) begin
          if (!m_pok[k]) m_pok[k] = 1;
          else if (good) begin
            m_hits[k]++;
            if (m_hits[k] == 2) begin
              m_lock[k] = 1; m_hits[k] = 0; m_miss[k] = 0;
            end
          end else m_hits[k] = 0;
        end else if (good) begin
          m_miss[k] = 0;
        end else begin
          m_err[k] = 1;
          m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
          m_miss[k]++;
          if (m_miss[k] == loss_n[k]) begin
            m_lock[k] = 0; m_miss[k] = 0; m_hits[k] = 0;
          end
        end
        m_prev[k] = s;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [2:0] s);
    rst = r; in_valid = v; {a, b, c} = s;
    @(posedge clk);
    model_edge(r, v, s);
    #1;
    chk("locked_a", 32'(lock_a), 32'(m_lock[0]));
    chk("err_a",    32'(err_a),  32'(m_err[0]));
    chk("errcnt_a", 32'(cnt_a),  32'(m_cnt[0]));
    chk("locked_b", 32'(lock_b), 32'(m_lock[1]));
    chk("err_b",    32'(err_b),  32'(m_err[1]));
    chk("errcnt_b", 32'(cnt_b),  32'(m_cnt[1]));
    if (m_lock[0]) chk("expected_a", 32'(exp_a), 32'(succ(3'(m_prev[0]))));
    if (m_lock[1]) chk("expected_b", 32'(exp_b), 32'(succ(3'(m_prev[1]))));
  endtask

  function automatic logic [2:0] bad_of(input int p);
    return succ(3'(p)) ^ 3'($urandom_range(1, 7));
  endfunction

  initial begin
    // Reset state.
    step(1, 0, 3'd0);
    step(1, 1, 3'd5);
    chk("rst_locked", 32'(lock_a), 0);
    chk("rst_errcnt", 32'(cnt_a), 0);

    // Lock on 000,101,010.
    step(0, 1, 3'b000);
    step(0, 1, 3'b101);
    step(0, 1, 3'b010);
    chk("lock_locked", 32'(lock_a), 1);
    chk("lock_expected", 32'(exp_a), 32'(3'b001));

    // Single error then recovery.
    step(0, 1, 3'b001);
    step(0, 1, 3'b000);
    chk("single_err", 32'(err_a), 1);
    chk("single_cnt", 32'(cnt_a), 1);
    step(0, 1, 3'b101);
    chk("single_noerr", 32'(err_a), 0);
    chk("single_still", 32'(lock_a), 1);
    step(0, 0, 3'b111);

    // Loss of lock on instance A, then relock.
    for (int i = 0; i < 3; i++) step(0, 1, bad_of(m_prev[0]));
    chk("loss_unlocked", 32'(lock_a), 0);
    chk("loss_cnt", 32'(cnt_a), 4);
    step(0, 1, succ(3'(m_prev[0])));
    step(0, 1, succ(3'(m_prev[0])));
    chk("relock", 32'(lock_a), 1);

    // Gaps between samples.
    step(1, 0, 3'd0);
    step(0, 1, 3'b000);
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, 7));
    step(0, 1, 3'b101);
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, 7));
    step(0, 1, 3'b010);
    chk("gap_locked", 32'(lock_a), 1);

    // Reach err_cnt=4 while locked, then reset with a bad sample present.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, bad_of(m_prev[0]));
      step(0, 1, succ(3'(m_prev[0])));
    end
    chk("pre_rst_cnt", 32'(cnt_a), 4);
    step(1, 1, bad_of(m_prev[0]));
    chk("midrst_locked", 32'(lock_a), 0);
    chk("midrst_err", 32'(err_a), 0);
    chk("midrst_cnt", 32'(cnt_a), 0);

    // Random traffic, mostly correct successors.
    for (int i = 0; i < 400; i++) begin
      bit r, v;
      logic [2:0] s;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) != 0) ? succ(3'(m_prev[0])) : 3'($urandom);
      step(r, v, s);
    end

    // Saturation on instance B: 300 mismatches, a correct sample every 6th.
    step(1, 0, 3'd0);
    step(0, 1, 3'b000);
    step(0, 1, 3'b101);
    step(0, 1, 3'b010);
    for (int blk = 0; blk < 60; blk++) begin
      for (int k = 0; k < 5; k++) step(0, 1, bad_of(m_prev[1]));
      if (blk != 59) step(0, 1, succ(3'(m_prev[1])));
    end
    chk("sat_cnt", 32'(cnt_b), 255);
    chk("sat_err", 32'(err_b), 1);
    chk("sat_locked", 32'(lock_b), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
